// File: rtl/jtag_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_pkg
// Purpose  : TAP state encoding, next-state function and default opcodes
//            shared by the oversampled JTAG TAP controller.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_tap_pkg;

  // 1149.1 Table 6-3 state encoding
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [31:0] DEF_IDCODE_VAL   = 32'h1000_0DB3;
  localparam logic [4:0]  DEF_INSTR_IDCODE = 5'h01;
  localparam logic [4:0]  DEF_INSTR_USER   = 5'h10;
  localparam logic [4:0]  DEF_INSTR_BYPASS = 5'h1F;

  // Standard 16-state TAP graph, advanced once per TCK rising edge
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_if
// Purpose  : Bit-banged JTAG pin bundle between the remote bridge (master)
//            and the TAP controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_tap_if;
  logic tck;
  logic tms;
  logic tdi;
  logic trst;
  logic tdo;

  modport master (output tck, output tms, output tdi, output trst, input tdo);
  modport slave  (input tck, input tms, input tdi, input trst, output tdo);
endinterface
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_fsm
// Purpose  : TCK edge detection in the clk_i domain, TAP state register and
//            synchronous TRST handling.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  input  wire logic  tck_i,
  input  wire logic  tms_i,
  input  wire logic  trst_i,
  output tap_state_e state_o,
  output tap_state_e state_d_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic       tck_q;
  tap_state_e state_q;
  tap_state_e state_d;

  assign rise_o    =  tck_i & ~tck_q;
  assign fall_o    = ~tck_i &  tck_q;
  assign state_o   = state_q;
  assign state_d_o = state_d;

  // Previous TCK level; a level held for many clks yields a single edge
  always_ff @(posedge clk_i) begin
    if (rst_i) tck_q <= 1'b0;
    else       tck_q <= tck_i;
  end

  // Next state: TRST wins over any coincident TCK edge
  always_comb begin
    state_d = state_q;
    if (trst_i)      state_d = TEST_LOGIC_RESET;
    else if (rise_o) state_d = tap_next(state_q, tms_i);
  end

  // TAP state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TEST_LOGIC_RESET;
    else       state_q <= state_d;
  end

endmodule
`default_nettype wire

// File: rtl/jtag_tap_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_oversampled
// Purpose  : IEEE 1149.1 TAP with IDCODE, BYPASS and one USER data register,
//            TCK oversampled as data in the clk_i domain.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_oversampled
  import jtag_tap_pkg::*;
#(
  parameter int                  IR_WIDTH     = 5,
  parameter int                  DR_WIDTH     = 32,
  parameter logic [31:0]         IDCODE_VAL   = DEF_IDCODE_VAL,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(DEF_INSTR_IDCODE),
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(DEF_INSTR_USER),
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = {IR_WIDTH{1'b1}}
)(
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  jtag_tap_if.slave                jtag,
  output logic [3:0]               tap_state_o,
  output logic [IR_WIDTH-1:0]      ir_o,
  output logic                     user_capture_o,
  input  wire logic [DR_WIDTH-1:0] user_data_i,
  output logic                     user_update_o,
  output logic [DR_WIDTH-1:0]      user_data_o
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e state_q;
  tap_state_e state_d;
  logic       rise;
  logic       fall;

  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [31:0]         id_shift_q;
  logic [DR_WIDTH-1:0] user_shift_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                user_capture_q;
  logic                user_update_q;
  logic [DR_WIDTH-1:0] user_data_q;

  // Shift sources: TDI enters at the MSB, the concat drops the old LSB
  logic [IR_WIDTH:0] w_ir_cat;
  logic [32:0]       w_id_cat;
  logic [DR_WIDTH:0] w_user_cat;
  logic              w_sel_idcode;
  logic              w_sel_user;
  logic              w_sel_bypass;
  logic              w_dr_lsb;

  assign w_ir_cat   = {jtag.tdi, ir_shift_q};
  assign w_id_cat   = {jtag.tdi, id_shift_q};
  assign w_user_cat = {jtag.tdi, user_shift_q};

  // Unknown opcodes fall back to BYPASS
  assign w_sel_idcode = (ir_q == INSTR_IDCODE);
  assign w_sel_user   = (ir_q == INSTR_USER);
  assign w_sel_bypass = (ir_q == INSTR_BYPASS) || !(w_sel_idcode || w_sel_user);
  assign w_dr_lsb     = w_sel_idcode ? id_shift_q[0] :
                        w_sel_user   ? user_shift_q[0] :
                        w_sel_bypass ? bypass_q : 1'b0;

  jtag_tap_fsm u_fsm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tck_i     (jtag.tck),
    .tms_i     (jtag.tms),
    .trst_i    (jtag.trst),
    .state_o   (state_q),
    .state_d_o (state_d),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // IR/DR datapath: capture and shift on TCK rise, TDO and update on fall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q           <= INSTR_IDCODE;
      ir_shift_q     <= '0;
      id_shift_q     <= '0;
      user_shift_q   <= '0;
      bypass_q       <= 1'b0;
      tdo_q          <= 1'b0;
      user_capture_q <= 1'b0;
      user_update_q  <= 1'b0;
      user_data_q    <= '0;
    end else begin
      user_capture_q <= 1'b0;
      user_update_q  <= 1'b0;

      if (rise && !jtag.trst) begin
        case (state_q)
          CAPTURE_IR: ir_shift_q <= IR_CAPTURE;
          SHIFT_IR:   ir_shift_q <= w_ir_cat[IR_WIDTH:1];
          CAPTURE_DR: begin
            if (w_sel_idcode) id_shift_q <= IDCODE_VAL;
            else if (w_sel_user) begin
              user_shift_q   <= user_data_i;
              user_capture_q <= 1'b1;
            end else bypass_q <= 1'b0;
          end
          SHIFT_DR: begin
            if (w_sel_idcode)    id_shift_q   <= w_id_cat[32:1];
            else if (w_sel_user) user_shift_q <= w_user_cat[DR_WIDTH:1];
            else                 bypass_q     <= jtag.tdi;
          end
          default: ;
        endcase
      end

      if (fall && !jtag.trst) begin
        if (state_q == SHIFT_IR)      tdo_q <= ir_shift_q[0];
        else if (state_q == SHIFT_DR) tdo_q <= w_dr_lsb;
        else                          tdo_q <= 1'b0;
        if (state_q == UPDATE_IR) ir_q <= ir_shift_q;
        if (state_q == UPDATE_DR && w_sel_user) begin
          user_data_q   <= user_shift_q;
          user_update_q <= 1'b1;
        end
      end

      // Entering or sitting in Test-Logic-Reset (TMS or TRST) pins IDCODE
      if (state_d == TEST_LOGIC_RESET) ir_q <= INSTR_IDCODE;
    end
  end

  assign jtag.tdo       = tdo_q;
  assign tap_state_o    = state_q;
  assign ir_o           = ir_q;
  assign user_capture_o = user_capture_q;
  assign user_update_o  = user_update_q;
  assign user_data_o    = user_data_q;

endmodule
`default_nettype wire

// File: doc/jtag_tap_oversampled.md
Name: jtag_tap_oversampled

Overview:
- IEEE 1149.1 TAP controller placed directly downstream of the DPI remote-bit-bang bridge.
- Consumes its tms/tck/tdi/trst outputs and returns tdo.
- TCK is treated as data, oversampled in the clk_i domain; there is no second clock.
- Implements IDCODE, BYPASS and one USER data register, with capture/update strobes towards the core.

Parameters:
IR_WIDTH, 5, instruction register width (>=2)
DR_WIDTH, 32, USER data register width (>=1)
IDCODE_VAL, 32'h1000_0DB3, IDCODE register contents (bit0 must be 1)
INSTR_IDCODE, 5'h01, IDCODE opcode
INSTR_USER, 5'h10, USER opcode
INSTR_BYPASS, 5'h1F, BYPASS opcode (all ones)

Ports:
clk_i  in  1  system clock; all logic on posedge
rst_i  in  1  synchronous active-high reset
jtag_tck_i  in  1  bit-banged TCK level, sampled as data
jtag_tms_i  in  1  TMS
jtag_tdi_i  in  1  TDI
jtag_trst_i  in  1  active-high TAP reset, sampled synchronously
jtag_tdo_o  out  1  TDO to the bridge
tap_state_o  out  4  current TAP state (package encoding)
ir_o  out  IR_WIDTH  current instruction
user_capture_o  out  1  one-clk pulse on USER Capture-DR
user_data_i  in  DR_WIDTH  value loaded into the USER shift register on capture
user_update_o  out  1  one-clk pulse on USER Update-DR
user_data_o  out  DR_WIDTH  USER update register, valid from the update pulse onward

Behaviour:
- Reset (rst_i): tck_q=0, state=TEST_LOGIC_RESET, IR=INSTR_IDCODE, all shift/update registers 0, jtag_tdo_o=0, strobes 0, user_data_o=0.
- Edge detect:
  - tck_q <= jtag_tck_i every clk.
  - rise = jtag_tck_i & ~tck_q; fall = ~jtag_tck_i & tck_q.
  - A level held for N clks produces exactly one edge.
  - TCK high and low times must each be >=1 clk.
- Rise actions (same clk as rise is seen):
  - FSM advances using jtag_tms_i, standard 16-state 1149.1 graph.
  - Five consecutive rises with TMS=1 reach TEST_LOGIC_RESET from any state.
  - Capture-IR: IR shift <= {zeros, 2'b01}.
  - Capture-DR:
    - IDCODE selected: shift <= IDCODE_VAL.
    - BYPASS selected: bypass <= 0.
    - USER selected: shift <= user_data_i and user_capture_o pulses.
  - Shift-IR / Shift-DR: the selected register shifts right; TDI enters at the MSB of the active length (1 bit for BYPASS).
- Fall actions:
  - In Shift-IR/Shift-DR, jtag_tdo_o <= LSB of the selected register; in all other states jtag_tdo_o <= 0.
  - Update-IR: IR <= IR shift.
  - Update-DR with USER selected: user_data_o <= shift and user_update_o pulses for one clk.
- Instruction decode: any opcode other than IDCODE or USER selects BYPASS.
- Entering TEST_LOGIC_RESET, by TMS or by trst, forces IR=INSTR_IDCODE.
- jtag_trst_i=1: next clk state=TEST_LOGIC_RESET and IR=IDCODE; it overrides a coincident rise or fall.
- Shift and update registers are untouched by trst, and trst produces no strobe.
- Latency: tdo is valid 1 clk after the clk in which fall is seen. The bridge samples tdo at the next tick, so it needs >=2 clk between the falling edge and its read.
- Strobes are single-clk pulses and never both high in the same clk.
- rst_i mid-shift aborts the operation with no update pulse.

Decomposition:
- jtag_tap_pkg:
  - tap_state_e: 16 states, 4-bit encoding per 1149.1 Table 6-3 values, TEST_LOGIC_RESET=4'hF.
  - next-state function tap_next(state, tms).
  - Default opcodes.
- Sub-module jtag_tap_fsm: tck edge detect plus state register plus trst handling; outputs state, rise, fall.
- The top contains the IR/DR datapath.

Test Plan:
- rst_i, then 5 TCK cycles TMS=1 -> tap_state_o=4'hF, ir_o=5'h01, jtag_tdo_o=0.
- After reset, go Shift-DR and shift 32 bits TDI=0 -> TDO sequence LSB-first equals 32'h1000_0DB3; IR capture path shows LSBs 2'b01 on the first two TDO bits.
- Load IR=5'h1F (also 5'h07, which decodes to BYPASS), shift 8 bits 8'hA5 -> TDO returns 0 followed by 8'hA5 delayed one TCK.
- Load USER, user_data_i=32'hDEADBEEF, shift in 32'h12345678 -> TDO yields DEADBEEF; one user_capture_o pulse; at Update-DR one user_update_o pulse and user_data_o=32'h12345678.
- Assert jtag_trst_i for 1 clk mid Shift-DR, coincident with a rise -> next clk state=4'hF, ir_o=5'h01, no user_update_o.
- Hold TCK high 10 clks then low 10 clks -> exactly one FSM advance.
- rst_i mid-shift -> all outputs return to reset values.
